// File: rtl/mips_pkg.sv
// Shared fetch-path types: default widths, queue entry layout and fetch FSM states.
package mips_pkg;
  localparam int ADDRESSWIDTH = 32;
  localparam int INSTRWIDTH   = 32;

  typedef struct packed {
    logic [INSTRWIDTH-1:0]   instr;
    logic [ADDRESSWIDTH-1:0] pc;
    logic [ADDRESSWIDTH-1:0] pc_plus4;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } ifq_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of packed fetch entries with push, pop, flush and occupancy count.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetch_entry_t)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] wen;

  assign do_pop  = pop && !flush && (count_reg != '0);
  assign do_push = push && !flush && ((count_reg != FULL) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wen
      assign wen[gi] = do_push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wen[i]) mem[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head reads as zero whenever the queue is empty, including after a flush.
  assign rd_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count   = count_reg;
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: one-outstanding imem request FSM and PC logic feeding a decoupling queue.
// Define IFQ_STATS_EN to add saturating stat_fetched / stat_flushed counters.
module instruction_fetch_queue #(
  parameter int ADDRESSWIDTH = mips_pkg::ADDRESSWIDTH,
  parameter int INSTRWIDTH   = mips_pkg::INSTRWIDTH,
  parameter int DEPTH        = 4,
  parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt_i,
  input  logic                    redirect_valid,
  input  logic [ADDRESSWIDTH-1:0] redirect_addr,
  output logic                    imem_req,
  output logic [ADDRESSWIDTH-1:0] imem_addr,
  input  logic                    imem_rvalid,
  input  logic [INSTRWIDTH-1:0]   imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTRWIDTH-1:0]   out_instr,
  output logic [ADDRESSWIDTH-1:0] out_pc,
  output logic [ADDRESSWIDTH-1:0] out_pc_plus4,
  output logic                    fetch_fault,
  output logic [$clog2(DEPTH):0]  queue_count
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]             stat_fetched,
  output logic [31:0]             stat_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [INSTRWIDTH-1:0]   instr;
    logic [ADDRESSWIDTH-1:0] pc;
    logic [ADDRESSWIDTH-1:0] pc_plus4;
  } entry_t;

  mips_pkg::ifq_state_t    state_reg, state_next;
  logic [ADDRESSWIDTH-1:0] pc_reg, pc_next;
  logic                    fault_reg, fault_next;
  logic [ADDRESSWIDTH:0]   pc_inc;
  logic [CW-1:0]           count_eff;
  logic                    pop, push, issue;
  entry_t                  wr_entry, rd_entry;

  assign pc_inc    = {1'b0, pc_reg} + (ADDRESSWIDTH + 1)'(4);
  assign out_valid = (queue_count != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign count_eff = queue_count - CW'(pop);
  assign push      = (state_reg == mips_pkg::WAIT) && imem_rvalid && !redirect_valid;
  // Gated by reset so no request strobe leaks out while reset is held.
  assign issue     = reset && (state_reg == mips_pkg::IDLE) && !halt_i && !fault_reg
                     && !redirect_valid && (count_eff < DEPTH_C);

  assign imem_req  = issue;
  assign imem_addr = pc_reg;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    if (redirect_valid) begin
      pc_next    = redirect_addr;
      fault_next = 1'b0;
    end
    case (state_reg)
      mips_pkg::IDLE: if (issue) state_next = mips_pkg::WAIT;
      mips_pkg::WAIT: begin
        if (imem_rvalid)         state_next = mips_pkg::IDLE;
        else if (redirect_valid) state_next = mips_pkg::DROP;
      end
      mips_pkg::DROP: if (imem_rvalid) state_next = mips_pkg::IDLE;
      default:        state_next = mips_pkg::IDLE;
    endcase
    if (push) begin
      pc_next = pc_inc[ADDRESSWIDTH-1:0];
      if (pc_inc[ADDRESSWIDTH]) fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= mips_pkg::IDLE;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  assign fetch_fault = fault_reg;

  assign wr_entry = '{instr: imem_rdata, pc: pc_reg, pc_plus4: pc_inc[ADDRESSWIDTH-1:0]};

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .rd_data(rd_entry),
    .count  (queue_count)
  );

  assign out_instr    = rd_entry.instr;
  assign out_pc       = rd_entry.pc;
  assign out_pc_plus4 = rd_entry.pc_plus4;

`ifdef IFQ_STATS_EN
  logic [31:0] fetched_reg, flushed_reg;
  logic        dropped;
  logic [32:0] flushed_sum;

  // A redirect discards every queued entry plus any response arriving for a stale request.
  assign dropped     = imem_rvalid && ((state_reg == mips_pkg::DROP)
                       || ((state_reg == mips_pkg::WAIT) && redirect_valid));
  assign flushed_sum = {1'b0, flushed_reg} + 33'(redirect_valid ? queue_count : CW'(0))
                       + 33'(dropped);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_reg <= '0;
      flushed_reg <= '0;
    end else begin
      if (push && (fetched_reg != '1)) fetched_reg <= fetched_reg + 1'b1;
      flushed_reg <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign stat_fetched = fetched_reg;
  assign stat_flushed = flushed_reg;
`endif
endmodule
